// File: rtl/uart_rx_fifo.sv
// UART receiver with majority-vote bit sampling, framing/parity/break
// detection and a first-word-fall-through receive FIFO.
module uart_rx_fifo #(
  parameter int unsigned DATA_WD    = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               rx,
  input  logic                               tick,
  input  logic                               rx_en,
  input  logic [3:0]                         data_len,
  input  logic [1:0]                         parity_mode,
  input  logic                               stop_bits,
  output logic [DATA_WD-1:0]                 m_data,
  output logic                               m_perr,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic                               rx_busy,
  output logic                               frame_err,
  output logic                               break_det,
  output logic                               overrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned FC_W  = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0] SAMP_A   = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] SAMP_B   = CNT_W'(OVERSAMPLE / 2);
  localparam logic [CNT_W-1:0] SAMP_C   = CNT_W'(OVERSAMPLE / 2 + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [FC_W-1:0]  DEPTH_C  = FC_W'(FIFO_DEPTH);
  localparam logic [3:0]       MAX_LEN  = 4'(DATA_WD);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_e;

  state_e               state_q, state_d;
  logic                 rx_meta_q, rx_sync_q;
  logic [CNT_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic [3:0]           len_q, len_d;
  logic [1:0]           pmode_q, pmode_d;
  logic                 stop2_q, stop2_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_WD-1:0]   data_q, data_d;
  logic                 samp_a_q, samp_a_d;
  logic                 samp_b_q, samp_b_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 zero_q, zero_d;
  logic                 frame_err_q, frame_err_d;
  logic                 break_q, break_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;

  logic [DATA_WD-1:0]   mem_data_q [FIFO_DEPTH];
  logic [DATA_WD-1:0]   mem_data_d [FIFO_DEPTH];
  logic                 mem_perr_q [FIFO_DEPTH];
  logic                 mem_perr_d [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [FC_W-1:0]      count_q, count_d;

  logic                 maj_c;
  logic                 frame_good_c;
  logic                 par_en_c;
  logic                 stop_bad_c;
  logic                 push_c, pop_c, full_c;

  // Two-flop synchronizer for the asynchronous serial line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Receiver next-state: oversample counting, bit capture and frame checks.
  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_idx_d    = bit_idx_q;
    len_d        = len_q;
    pmode_d      = pmode_q;
    stop2_d      = stop2_q;
    stop_idx_d   = stop_idx_q;
    data_d       = data_q;
    samp_a_d     = samp_a_q;
    samp_b_d     = samp_b_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    zero_d       = zero_q;
    frame_err_d  = 1'b0;
    break_d      = 1'b0;
    frame_good_c = 1'b0;
    par_en_c     = (pmode_q == 2'd1) || (pmode_q == 2'd2);
    maj_c        = (samp_a_q & samp_b_q) | (samp_a_q & rx_sync_q) | (samp_b_q & rx_sync_q);
    stop_bad_c   = ferr_q | ~maj_c;

    if (tick && (state_q != S_IDLE) && (state_q != S_WAIT_HIGH)) begin
      if (tick_cnt_q == SAMP_A) samp_a_d = rx_sync_q;
      if (tick_cnt_q == SAMP_B) samp_b_d = rx_sync_q;
      tick_cnt_d = (tick_cnt_q == CNT_LAST) ? '0 : tick_cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (tick && rx_en && !rx_sync_q) begin
          state_d    = S_START;
          tick_cnt_d = '0;
          len_d      = ((data_len >= 4'd5) && (data_len <= MAX_LEN)) ? data_len : MAX_LEN;
          pmode_d    = parity_mode;
          stop2_d    = stop_bits;
          stop_idx_d = 1'b0;
          bit_idx_d  = '0;
          data_d     = '0;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
          zero_d     = 1'b1;
        end
      end
      S_START: begin
        if (tick) begin
          if ((tick_cnt_q == SAMP_C) && maj_c) begin
            state_d = S_IDLE;
          end else if (tick_cnt_q == CNT_LAST) begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (tick_cnt_q == SAMP_C) begin
            for (int i = 0; i < DATA_WD; i++) begin
              if (bit_idx_q == 4'(i)) data_d[i] = maj_c;
            end
            if (maj_c) zero_d = 1'b0;
          end
          if (tick_cnt_q == CNT_LAST) begin
            if (bit_idx_q == len_q - 4'd1) begin
              state_d = par_en_c ? S_PARITY : S_STOP;
            end else begin
              bit_idx_d = bit_idx_q + 4'd1;
            end
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          if (tick_cnt_q == SAMP_C) begin
            perr_d = (^data_q) ^ maj_c ^ (pmode_q == 2'd1);
            if (maj_c) zero_d = 1'b0;
          end
          if (tick_cnt_q == CNT_LAST) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (tick_cnt_q == SAMP_C) begin
            if (stop_idx_q == stop2_q) begin
              // Final stop bit: finish half a bit early to resync on next start.
              if (stop_bad_c) begin
                frame_err_d = 1'b1;
                break_d     = zero_q & ~maj_c;
                state_d     = S_WAIT_HIGH;
              end else begin
                frame_good_c = 1'b1;
                state_d      = S_IDLE;
              end
            end else begin
              ferr_d = stop_bad_c;
              if (maj_c) zero_d = 1'b0;
            end
          end else if (tick_cnt_q == CNT_LAST) begin
            stop_idx_d = 1'b1;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (rx_sync_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // FIFO next-state: push completed frames, pop on handshake.
  always_comb begin
    mem_data_d = mem_data_q;
    mem_perr_d = mem_perr_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    pop_c      = (count_q != '0) && m_ready;
    full_c     = (count_q == DEPTH_C);
    push_c     = frame_good_c && (!full_c || pop_c);
    overrun_d  = frame_good_c && full_c && !pop_c;

    if (push_c) begin
      mem_data_d[wr_ptr_q] = data_q;
      mem_perr_d[wr_ptr_q] = perr_q;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push_c, pop_c})
      2'b10:   count_d = count_q + FC_W'(1);
      2'b01:   count_d = count_q - FC_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tick_cnt_q  <= '0;
      bit_idx_q   <= '0;
      len_q       <= MAX_LEN;
      pmode_q     <= 2'd0;
      stop2_q     <= 1'b0;
      stop_idx_q  <= 1'b0;
      data_q      <= '0;
      samp_a_q    <= 1'b1;
      samp_b_q    <= 1'b1;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      zero_q      <= 1'b0;
      frame_err_q <= 1'b0;
      break_q     <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
      mem_data_q  <= '{default: '0};
      mem_perr_q  <= '{default: 1'b0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_idx_q   <= bit_idx_d;
      len_q       <= len_d;
      pmode_q     <= pmode_d;
      stop2_q     <= stop2_d;
      stop_idx_q  <= stop_idx_d;
      data_q      <= data_d;
      samp_a_q    <= samp_a_d;
      samp_b_q    <= samp_b_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      zero_q      <= zero_d;
      frame_err_q <= frame_err_d;
      break_q     <= break_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
      mem_data_q  <= mem_data_d;
      mem_perr_q  <= mem_perr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  assign m_data     = mem_data_q[rd_ptr_q];
  assign m_perr     = mem_perr_q[rd_ptr_q];
  assign m_valid    = (count_q != '0);
  assign fifo_count = count_q;
  assign rx_busy    = busy_q;
  assign frame_err  = frame_err_q;
  assign break_det  = break_q;
  assign overrun    = overrun_q;

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DATA_WD, default 8, maximum data bits per frame.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, ticks per bit; even, >=8.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries; power of 2, >=2.
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port rx  input  1  serial line, idle high, asynchronous to clk.
REQ-007 SHALL have port tick  input  1  one-clk oversample pulse from baud generator.
REQ-008 SHALL have port rx_en  input  1  enables detection of new start bits.
REQ-009 SHALL have port data_len  input  4  data bits per frame, 5..DATA_WD; other values treated as DATA_WD.
REQ-010 SHALL have port parity_mode  input  2  0 none, 1 odd, 2 even, 3 none.
REQ-011 SHALL have port stop_bits  input  1  0: one stop bit, 1: two stop bits.
REQ-012 SHALL have port m_data  output  DATA_WD  FIFO head data, zero-extended above data_len.
REQ-013 SHALL have port m_perr  output  1  parity-error tag of FIFO head entry.
REQ-014 SHALL have port m_valid  output  1  FIFO non-empty.
REQ-015 SHALL have port m_ready  input  1  consumer accepts head entry.
REQ-016 SHALL have port rx_busy  output  1  frame in progress.
REQ-017 SHALL have port frame_err  output  1  one-clk pulse, frame dropped on bad stop bit.
REQ-018 SHALL have port break_det  output  1  one-clk pulse, line-break frame detected.
REQ-019 SHALL have port overrun  output  1  one-clk pulse, good frame dropped, FIFO full.
REQ-020 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH+1)  entries held.

Function
REQ-021 rx SHALL pass a 2-flop synchronizer (reset value 1); all decisions use the synchronized value.
REQ-022 States SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_HIGH; tick_cnt counts 0..OVERSAMPLE-1 per bit, advancing only on tick.
REQ-023 Each bit value SHALL be the 2-of-3 majority of samples at tick_cnt OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1.
REQ-024 IDLE -> START on a tick with rx_en=1 and synced rx=0; tick_cnt cleared; data_len, parity_mode, stop_bits latched for the whole frame.
REQ-025 START: majority 1 -> IDLE (false start, no flags, no FIFO write); else at tick_cnt OVERSAMPLE-1 -> DATA.
REQ-026 DATA: bits stored LSB first; after latched data_len bits, at tick_cnt OVERSAMPLE-1 -> PARITY if parity enabled, else STOP.
REQ-027 PARITY: odd mode expects XOR(data, parity bit)=1, even expects 0; mismatch sets entry m_perr=1, frame still stored.
REQ-028 STOP: one or two stop bits; any stop majority 0 marks framing error; frame completes on final stop bit's last sample tick, returning to IDLE (half-bit resync margin).
REQ-029 Good frame completion SHALL write {perr, data} to FIFO if not full; if full, frame dropped and overrun pulses.
REQ-030 Framing error SHALL drop the frame, pulse frame_err, and enter WAIT_HIGH; if all data bits, parity bit (if any) and stop bit are 0, break_det pulses in the same cycle.
REQ-031 WAIT_HIGH -> IDLE once synced rx=1; no start detection before then.
REQ-032 rx_busy SHALL be 1 in START, DATA, PARITY, STOP, WAIT_HIGH, else 0.
REQ-033 Deasserting rx_en mid-frame SHALL not abort the frame; it gates only new starts.
REQ-034 FIFO is first-word-fall-through: m_valid rises the clk after the write; entry popped when m_valid && m_ready.
REQ-035 Simultaneous push and pop when full SHALL both succeed, no overrun, fifo_count unchanged.
REQ-036 Push and pop pointers wrap modulo FIFO_DEPTH; pop when empty is ignored.

Reset
REQ-037 rst_n=0 SHALL immediately force IDLE, empty FIFO, m_data=0, m_perr=0, m_valid=0, rx_busy=0, frame_err=0, break_det=0, overrun=0, fifo_count=0.
REQ-038 Reset asserted mid-frame SHALL discard the partial frame; after release, reception resumes only on a new start bit.

Verification
REQ-039 8N1, byte 0xA5, m_ready=1 -> m_data=0xA5, m_perr=0, m_valid high one clk, no error pulses.
REQ-040 data_len=7, even parity, 0x35 sent with parity bit 1 -> entry 0x35 stored with m_perr=1.
REQ-041 stop_bits=1, second stop bit 0 -> frame_err pulse, no FIFO write, rx_busy held until rx high.
REQ-042 rx low for 12 bit times then high -> frame_err and break_det pulse together once; next frame 0x5A received correctly.
REQ-043 FIFO_DEPTH=4, m_ready=0, five frames 0x01..0x05 -> fifo_count=4, overrun on fifth; drain yields 0x01..0x04.
REQ-044 rx low for 3 ticks only -> no frame, no flags, rx_busy returns 0 within one bit time.
